// File: rtl/timer_pkg.sv
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types, digit limits and BCD packing for the MM:SS timer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] DIG_MAX   = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;

    localparam int SEC_U_LSB = 0;
    localparam int SEC_T_LSB = 4;
    localparam int MIN_U_LSB = 8;
    localparam int MIN_T_LSB = 12;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
        return (d > max) ? max : d;
    endfunction

    function automatic logic [15:0] clamp_preset(input logic [15:0] p);
        logic [15:0] r;
        r = '0;
        r[MIN_T_LSB +: 4] = clamp_digit(p[MIN_T_LSB +: 4], DIG_MAX);
        r[MIN_U_LSB +: 4] = clamp_digit(p[MIN_U_LSB +: 4], DIG_MAX);
        r[SEC_T_LSB +: 4] = clamp_digit(p[SEC_T_LSB +: 4], SEC_T_MAX);
        r[SEC_U_LSB +: 4] = clamp_digit(p[SEC_U_LSB +: 4], DIG_MAX);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_digit.sv
// ============================================================================
//  Module      : bcd_down_digit
//  Description : One BCD down-count digit that wraps to MAX and emits a borrow.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_down_digit
    import timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIG_MAX
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       ld,
    input  logic [3:0] d,
    input  logic       en,
    output logic [3:0] q,
    output logic       zero,
    output logic       borrow
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    assign zero   = (q_q == 4'd0);
    assign borrow = en & zero;
    assign q      = q_q;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = 4'd0;
        end else if (ld) begin
            q_d = d;
        end else if (en) begin
            q_d = zero ? MAX : (q_q - 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

endmodule

`default_nettype wire

// File: rtl/timer_mmss_ctrl.sv
// ============================================================================
//  Module      : timer_mmss_ctrl
//  Description : MM:SS countdown sequencer - FSM, 1 s prescaler, clamp, expiry.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module timer_mmss_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] preset,
    input  logic        start,
    input  logic        pause,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    localparam int              PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;

    logic        tick;
    logic        ld_acc;
    logic [15:0] preset_clamped;
    logic [15:0] dig_q;
    logic [3:0]  dig_zero;
    logic [3:0]  dig_borrow;
    logic [3:0]  dig_en;
    logic        time_zero;
    logic        last_sec;

    assign preset_clamped = clamp_preset(preset);
    assign ld_acc         = !clear && load && (state_q != ST_RUN);
    assign tick           = !clear && (state_q == ST_RUN) && !pause && (pre_q == PRE_LAST);
    assign dig_en         = {dig_borrow[2:0], tick};
    assign time_zero      = &dig_zero;
    assign last_sec       = dig_zero[3] && dig_zero[2] && dig_zero[1]
                            && (dig_q[SEC_U_LSB +: 4] == 4'd1);

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_down_digit #(
            .MAX ((i == 1) ? SEC_T_MAX : DIG_MAX)
        ) u_digit (
            .clk    (clk),
            .clear  (clear),
            .ld     (ld_acc),
            .d      (preset_clamped[4*i +: 4]),
            .en     (dig_en[i]),
            .q      (dig_q[4*i +: 4]),
            .zero   (dig_zero[i]),
            .borrow (dig_borrow[i])
        );
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        done_d  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
        end else if (ld_acc) begin
            state_d = ST_IDLE;
            pre_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        pre_d = '0;
                        // A top-digit borrow means 0000 underflowed; treat it as expiry too.
                        if (last_sec || dig_borrow[3]) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start && !time_zero) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                    end
                end
                ST_PAUSE: begin
                    if (start && !time_zero) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        pre_q     <= pre_d;
        running_q <= running_d;
        done_q    <= done_d;
        alarm_q   <= alarm_d;
    end

    assign time_bcd = dig_q;
    assign running  = running_q;
    assign done     = done_q;
    assign alarm    = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_mmss_ctrl.sv
// ============================================================================
//  Module      : tb_timer_mmss_ctrl
//  Description : Directed scoreboard bench for timer_mmss_ctrl with TICK_DIV = 4.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_timer_mmss_ctrl;

    logic        clk = 1'b0;
    logic        clear;
    logic        load;
    logic [15:0] preset;
    logic        start;
    logic        pause;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;
    logic        alarm;

    always #5 clk = ~clk;

    timer_mmss_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .load     (load),
        .preset   (preset),
        .start    (start),
        .pause    (pause),
        .time_bcd (time_bcd),
        .running  (running),
        .done     (done),
        .alarm    (alarm)
    );

    typedef struct {
        string       tag;
        logic [15:0] t;
        logic        r;
        logic        d;
        logic        a;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string tag, input logic [15:0] t,
                        input logic r, input logic d, input logic a);
        exp_t e;
        e.tag = tag;
        e.t   = t;
        e.r   = r;
        e.d   = d;
        e.a   = a;
        sb.push_back(e);
    endtask

    // Inputs set before a step are sampled on its edge; outputs are checked 1 ns later.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            assert ({time_bcd, running, done, alarm} === {e.t, e.r, e.d, e.a})
            else begin
                n_bad++;
                $error("FAIL %s: observed time=%h run=%b done=%b alarm=%b expected time=%h run=%b done=%b alarm=%b",
                       e.tag, time_bcd, running, done, alarm, e.t, e.r, e.d, e.a);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic c, input logic l, input logic [15:0] p,
                         input logic s, input logic pa);
        clear  = c;
        load   = l;
        preset = p;
        start  = s;
        pause  = pa;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        push("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();

        // Countdown to expiry
        drive(1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        push("load_0002", 16'h0002, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        push("start_run", 16'h0002, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(3);
        push("dec_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
        step();
        idle(3);
        push("expire", 16'h0000, 1'b0, 1'b1, 1'b1);
        step();
        push("done_falls", 16'h0000, 1'b0, 1'b0, 1'b1);
        step();

        // Start ignored in DONE, load leaves it
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        push("start_in_done", 16'h0000, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        push("load_from_done", 16'h0001, 1'b0, 1'b0, 1'b0);
        step();

        // Full borrow chain
        drive(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        push("load_1000", 16'h1000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        push("start_1000", 16'h1000, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(3);
        push("borrow_0959", 16'h0959, 1'b1, 1'b0, 1'b0);
        step();
        idle(3);
        push("dec_0958", 16'h0958, 1'b1, 1'b0, 1'b0);
        step();

        // Ignored load in RUN, start+pause, resume, clear mid-RUN
        drive(1'b0, 1'b1, 16'h0500, 1'b0, 1'b0);
        push("load_in_run", 16'h0958, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        push("start_pause", 16'h0958, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        push("resume", 16'h0958, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        push("clear_mid_run", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();

        // Start with 0000 is ignored
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        push("zero_start", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        push("zero_start_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();

        // Pause and resume with retained prescaler
        drive(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
        push("load_0005", 16'h0005, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        push("start_0005", 16'h0005, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(3);
        push("dec_0004", 16'h0004, 1'b1, 1'b0, 1'b0);
        step();
        idle(2);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        push("pause_at_2", 16'h0004, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push("paused_hold", 16'h0004, 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        push("resume_run", 16'h0004, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        push("resume_plus1", 16'h0004, 1'b1, 1'b0, 1'b0);
        step();
        push("resume_dec", 16'h0003, 1'b1, 1'b0, 1'b0);
        step();

        // Clamp on load
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        push("clear_before_clamp", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 16'hA7C3, 1'b0, 1'b0);
        push("clamp_A7C3", 16'h9753, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 16'h006A, 1'b0, 1'b0);
        push("clamp_006A", 16'h0059, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        push("clamp_FFFF", 16'h9959, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
